ram_param: RTL and testbench

RAM_PARAM -- requirements
Module: ram_param

---
 rtl/ram_param.sv | 190 +++++++++++++++++++
 tb/tb_ram_param.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_param.sv
// ram_param -- single-port, byte-lane-writable synchronous RAM with a
// valid/ready request port and a fixed-latency read response.
//
// Optional feature macro: RAM_CLEAR_EN
//   defined   : after reset the array is zero-filled one word per cycle
//               (CLEAR state, DEPTH cycles) before requests are accepted.
//   undefined : requests are accepted from the first cycle after reset;
//               array contents are undefined until written.
//
// Parameters
//   DATA_W   word width in bits
//   ADDR_W   address width, DEPTH = 2**ADDR_W words
//   BYTE_W   bits per byte lane (DATA_W must be a multiple of BYTE_W)
//   READ_LAT accepted-read to rsp_valid latency, 1 or 2 cycles
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset (control and output regs only)
//   req_valid  request present
//   req_ready  request accepted when req_valid && req_ready
//   write_n    0 = write, 1 = read
//   addr       word address
//   data_in    write data
//   byte_en    per-lane write enable
//   rsp_valid  one-cycle pulse marking valid read data
//   data_out   read data, held while rsp_valid is 0
module ram_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 10,
    parameter int BYTE_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     write_n,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [DATA_W/BYTE_W-1:0] byte_en,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        data_out
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic rd_acc;
    logic wr_acc;

    assign req_ready = (state == RUN);
    // A request presented while rst is high is never acted on.
    assign rd_acc = req_valid && req_ready &&  write_n && !rst;
    assign wr_acc = req_valid && req_ready && !write_n && !rst;

`ifdef RAM_CLEAR_EN
    localparam state_t RST_STATE = CLEAR;

    logic [ADDR_W-1:0] clr_addr;
    logic              clr_last;

    assign clr_last = &clr_addr;

    // Reset always restarts the sweep at address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_addr <= '0;
        end else if (state == CLEAR) begin
            clr_addr <= clr_addr + ADDR_W'(1);
        end
    end
`else
    localparam state_t RST_STATE = RUN;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR: begin
`ifdef RAM_CLEAR_EN
                if (clr_last) begin
                    state_nxt = RUN;
                end
`else
                state_nxt = RUN;
`endif
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = RST_STATE;
        endcase
    end

    // Array write port: clear sweep or byte-lane write. Never touched by rst
    // itself; the clear write is suppressed while rst is held.
`ifdef RAM_CLEAR_EN
    always_ff @(posedge clk) begin
        if (state == CLEAR && !rst) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (byte_en[i]) begin
                    mem[addr][i*BYTE_W +: BYTE_W] <= data_in[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (byte_en[i]) begin
                    mem[addr][i*BYTE_W +: BYTE_W] <= data_in[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end
`endif

    // ---- stage p0: array read register ----
    logic              vld_p0;
    logic [DATA_W-1:0] data_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= rd_acc;
        end
    end

    // Loads only on an accepted read so the last read value is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p0 <= '0;
        end else if (rd_acc) begin
            data_p0 <= mem[addr];
        end
    end

    // ---- stage p1: optional output register ----
    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              vld_p1;
            logic [DATA_W-1:0] data_p1;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p1 <= 1'b0;
                end else begin
                    vld_p1 <= vld_p0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_p1 <= '0;
                end else if (vld_p0) begin
                    data_p1 <= data_p0;
                end
            end

            // Masking with rst keeps a read accepted just before reset from
            // surfacing in the reset cycle itself.
            assign rsp_valid = vld_p1 && !rst;
            assign data_out  = data_p1;
        end else begin : g_lat1
            assign rsp_valid = vld_p0 && !rst;
            assign data_out  = data_p0;
        end
    endgenerate

endmodule

// File: tb/tb_ram_param.sv
module tb_ram_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        write_n;
    logic [9:0]  addr;
    logic [15:0] data_in;
    logic [1:0]  byte_en;

    logic        ready1, ready2;
    logic        rv1, rv2;
    logic [15:0] do1, do2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ram_param #(.DATA_W(16), .ADDR_W(10), .BYTE_W(8), .READ_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1),
        .write_n(write_n), .addr(addr), .data_in(data_in), .byte_en(byte_en),
        .rsp_valid(rv1), .data_out(do1)
    );

    ram_param #(.DATA_W(16), .ADDR_W(10), .BYTE_W(8), .READ_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready2),
        .write_n(write_n), .addr(addr), .data_in(data_in), .byte_en(byte_en),
        .rsp_valid(rv2), .data_out(do2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [9:0] a, input logic [15:0] d, input logic [1:0] be);
        req_valid = 1'b1;
        write_n   = 1'b0;
        addr      = a;
        data_in   = d;
        byte_en   = be;
        check("wr_ready1", 32'(ready1), 32'd1);
        check("wr_ready2", 32'(ready2), 32'd1);
        tick();
        req_valid = 1'b0;
        write_n   = 1'b1;
        check("wr_norsp1", 32'(rv1), 32'd0);
        check("wr_norsp2", 32'(rv2), 32'd0);
    endtask

    task automatic do_read(input logic [9:0] a, input logic [15:0] exp);
        req_valid = 1'b1;
        write_n   = 1'b1;
        addr      = a;
        tick();
        req_valid = 1'b0;
        check("rd_l1_vld",   32'(rv1), 32'd1);
        check("rd_l1_data",  32'(do1), 32'(exp));
        check("rd_l2_early", 32'(rv2), 32'd0);
        tick();
        check("rd_l1_pulse", 32'(rv1), 32'd0);
        check("rd_l1_hold",  32'(do1), 32'(exp));
        check("rd_l2_vld",   32'(rv2), 32'd1);
        check("rd_l2_data",  32'(do2), 32'(exp));
        tick();
        check("rd_l2_pulse", 32'(rv2), 32'd0);
        check("rd_l2_hold",  32'(do2), 32'(exp));
    endtask

`ifdef RAM_CLEAR_EN
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!(ready1 && ready2) && n < 2000) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'd1024);
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        write_n   = 1'b1;
        addr      = '0;
        data_in   = '0;
        byte_en   = '0;
        tick();
        tick();
        tick();
        check("rst_rv1", 32'(rv1), 32'd0);
        check("rst_rv2", 32'(rv2), 32'd0);
        check("rst_do1", 32'(do1), 32'd0);
        check("rst_do2", 32'(do2), 32'd0);

        rst = 1'b0;
`ifdef RAM_CLEAR_EN
        check("clr_rdy0", 32'(ready1), 32'd0);
        wait_ready("clr_len");
        do_read(10'd5, 16'h0000);
`else
        check("rdy_first1", 32'(ready1), 32'd1);
        check("rdy_first2", 32'(ready2), 32'd1);
`endif

        // Fill 0..15, then stream 16 reads back-to-back.
        for (int i = 0; i < 16; i++) begin
            do_write(10'(i), 16'(i), 2'b11);
        end
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                req_valid = 1'b1;
                write_n   = 1'b1;
                addr      = 10'(i);
            end else begin
                req_valid = 1'b0;
            end
            tick();
            if (i < 16) begin
                check("b2b_l1_vld",  32'(rv1), 32'd1);
                check("b2b_l1_data", 32'(do1), 32'(i));
            end else begin
                check("b2b_l1_idle", 32'(rv1), 32'd0);
            end
            if (i >= 1 && i <= 16) begin
                check("b2b_l2_vld",  32'(rv2), 32'd1);
                check("b2b_l2_data", 32'(do2), 32'(i - 1));
            end else begin
                check("b2b_l2_idle", 32'(rv2), 32'd0);
            end
        end

        // Byte-lane writes.
        do_write(10'd3, 16'hABCD, 2'b11);
        do_write(10'd3, 16'h1234, 2'b01);
        do_read(10'd3, 16'hAB34);
        do_write(10'd3, 16'hFFFF, 2'b00);
        do_read(10'd3, 16'hAB34);
        do_write(10'd3, 16'h5600, 2'b10);
        do_read(10'd3, 16'h5634);

        do_write(10'd7, 16'h00FF, 2'b11);
        do_read(10'd7, 16'h00FF);

        do_write(10'd1023, 16'h5A5A, 2'b11);
        do_read(10'd1023, 16'h5A5A);

        // Read accepted, then reset asserted the next cycle.
        req_valid = 1'b1;
        write_n   = 1'b1;
        addr      = 10'd3;
        tick();
        req_valid = 1'b0;
        rst       = 1'b1;
        #1;
        check("rstmid_rv1_now", 32'(rv1), 32'd0);
        check("rstmid_rv2_now", 32'(rv2), 32'd0);
        tick();
        check("rstmid_rv1", 32'(rv1), 32'd0);
        check("rstmid_rv2", 32'(rv2), 32'd0);
        check("rstmid_do1", 32'(do1), 32'd0);
        check("rstmid_do2", 32'(do2), 32'd0);
        rst = 1'b0;
        tick();
        check("rstmid_late_rv1", 32'(rv1), 32'd0);
        check("rstmid_late_rv2", 32'(rv2), 32'd0);
`ifdef RAM_CLEAR_EN
        repeat (99) tick();
        check("clr_mid_rdy", 32'(ready1), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready("clr_restart_len");
        do_read(10'd3, 16'h0000);
        do_read(10'd1023, 16'h0000);
`else
        check("rst_rdy1", 32'(ready1), 32'd1);
        do_read(10'd3, 16'h5634);
        do_read(10'd1023, 16'h5A5A);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
